// File: rtl/ifetch_pkg.sv
// Shared fetch constants, FSM state and the skid-buffer entry type.
// Used by instr_fetch_unit and ifetch_skid_fifo.
package ifetch_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] inst;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Synchronous FIFO of fetch entries, head visible combinationally from storage; 1-cycle push-to-head.
// No internal backpressure: the caller must never push when full or pop when empty; flush wins.
module ifetch_skid_fifo
  import ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Power-of-two depth lets the pointers wrap without a compare.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one-cycle memory read, 2-entry skid buffer to decode, halts on HALT_WORD/top of memory.
// i_stall holds the head; issue runs on FIFO credit so no word is lost. IFETCH_PERF_EN adds perf counters.
module instr_fetch_unit
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  o_dir,
  input  logic [INSTR_W-1:0] i_inst,
  input  logic               i_stall,
  input  logic               i_branch_valid,
  input  logic [ADDR_W-1:0]  i_branch_target,
  output logic [INSTR_W-1:0] o_inst,
  output logic [ADDR_W-1:0]  o_inst_pc,
  output logic               o_inst_valid,
  output logic               o_halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]        o_perf_fetched,
  output logic [15:0]        o_perf_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_pc;
  logic              inflight;
  logic              kill;

  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      head;
  fetch_entry_t      push_dat;
  logic              ret_live;
  logic              ret_halt;
  logic              push;
  logic              pop;
  logic              issue;

  assign ret_live = inflight && !kill;
  assign ret_halt = ret_live && (i_inst == HALT_WORD);
  assign push     = ret_live && !ret_halt && !i_branch_valid;
  assign pop      = o_inst_valid && !i_stall && !i_branch_valid;
  assign push_dat = '{inst: i_inst, pc: ret_pc};

  // Credit counts the word already in flight; a same-cycle pop frees a slot for 1 word/cycle.
  assign issue = (state == RUN) && !ret_halt && (pc <= LAST_ADDR) &&
                 ((int'(fifo_count) + int'(inflight) - int'(pop)) < int'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= '0;
      o_dir    <= '0;
      ret_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      o_halted <= 1'b0;
    end else if (i_branch_valid) begin
      pc       <= i_branch_target;
      ret_pc   <= o_dir;
      inflight <= issue;
      kill     <= 1'b1;
      if (i_branch_target <= LAST_ADDR) begin
        o_dir    <= i_branch_target;
        state    <= RUN;
        o_halted <= 1'b0;
      end else begin
        state    <= HALT;
        o_halted <= 1'b1;
      end
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        ret_pc <= pc;
        pc     <= pc + ADDR_W'(1);
        if (pc != LAST_ADDR) o_dir <= pc + ADDR_W'(1);
      end
      if (ret_halt || (push && (ret_pc == LAST_ADDR))) begin
        state    <= HALT;
        o_halted <= 1'b1;
      end
    end
  end

  ifetch_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (i_branch_valid),
    .count    (fifo_count),
    .head     (head)
  );

  assign o_inst       = head.inst;
  assign o_inst_pc    = head.pc;
  assign o_inst_valid = (fifo_count != '0);

`ifdef IFETCH_PERF_EN
  logic [CNT_W:0] discard_n;
  logic [16:0]    fetched_sum;
  logic [16:0]    flushed_sum;

  always_comb begin
    discard_n = '0;
    if (i_branch_valid) discard_n = {1'b0, fifo_count};
    if (inflight && (kill || i_branch_valid)) discard_n = discard_n + (CNT_W + 1)'(1);
  end

  assign fetched_sum = {1'b0, o_perf_fetched} + 17'(pop);
  assign flushed_sum = {1'b0, o_perf_flushed} + 17'(discard_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_fetched <= '0;
      o_perf_flushed <= '0;
    end else begin
      o_perf_fetched <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
      o_perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random stall/branch traffic
// against a program-order stream model of the instruction memory.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  localparam int MW = $clog2(MEM_DEPTH);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [ADDR_W-1:0]  o_dir;
  logic [INSTR_W-1:0] i_inst = '0;
  logic               i_stall;
  logic               i_branch_valid;
  logic [ADDR_W-1:0]  i_branch_target;
  logic [INSTR_W-1:0] o_inst;
  logic [ADDR_W-1:0]  o_inst_pc;
  logic               o_inst_valid;
  logic               o_halted;
`ifdef IFETCH_PERF_EN
  logic [15:0]        o_perf_fetched;
  logic [15:0]        o_perf_flushed;
`endif

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_dir           (o_dir),
    .i_inst          (i_inst),
    .i_stall         (i_stall),
    .i_branch_valid  (i_branch_valid),
    .i_branch_target (i_branch_target),
    .o_inst          (o_inst),
    .o_inst_pc       (o_inst_pc),
    .o_inst_valid    (o_inst_valid),
    .o_halted        (o_halted)
`ifdef IFETCH_PERF_EN
    ,
    .o_perf_fetched  (o_perf_fetched),
    .o_perf_flushed  (o_perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: address sampled at the edge, word valid the next cycle.
  logic [INSTR_W-1:0] mem [MEM_DEPTH];
  always @(posedge clk) i_inst <= mem[o_dir[MW-1:0]];

  int checks = 0;
  int errors = 0;
  int exp_pc, pops, idle, max_idle, max_dir;
  bit dir_oob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A program segment legitimately ends at a halt word or past the top of memory.
  function automatic bit ends_at(input int p);
    if (p >= int'(MEM_DEPTH)) return 1'b1;
    return mem[p] == HALT_WORD;
  endfunction

  task automatic fill_mem(input int halt_pct);
    logic [INSTR_W-1:0] w;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      w = INSTR_W'($urandom);
      if (w == HALT_WORD) w = 16'h1234;
      if (int'($urandom_range(99)) < halt_pct) w = HALT_WORD;
      mem[i] = w;
    end
  endtask

  task automatic do_reset();
    i_stall = 1'b0;
    i_branch_valid = 1'b0;
    i_branch_target = '0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", o_inst_valid, 0);
    check("rst_dir", o_dir, 0);
    check("rst_halted", o_halted, 0);
    check("rst_inst", o_inst, 0);
    check("rst_inst_pc", o_inst_pc, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 0;
    pops = 0;
    max_dir = 0;
    idle = 0;
  endtask

  // One clock: drive inputs, check any word decode consumes against program order, advance.
  task automatic cycle(input bit stall, input bit br, input int tgt);
    bit popped;
    i_stall = stall;
    i_branch_valid = br;
    i_branch_target = ADDR_W'(tgt);
    popped = o_inst_valid && !stall && !br;
    if (o_halted && !o_inst_valid) check("halt_point", ends_at(exp_pc), 1);
    if (popped) begin
      check("pop_not_end", ends_at(exp_pc), 0);
      check("pop_pc", o_inst_pc, exp_pc);
      check("pop_inst", o_inst, mem[exp_pc % int'(MEM_DEPTH)]);
      exp_pc++;
      pops++;
    end
    if (br) exp_pc = tgt;
    if (br || popped) idle = 0;
    else if (!stall && !o_halted) idle++;
    if (idle > max_idle) max_idle = idle;
    @(posedge clk);
    @(negedge clk);
    if (o_dir >= ADDR_W'(MEM_DEPTH)) dir_oob = 1'b1;
    if (int'(o_dir) > max_dir) max_dir = int'(o_dir);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [INSTR_W-1:0] prog [5];
    int n;
    bit stall, br;
    prog = '{16'hb300, 16'hb200, 16'hb100, 16'h8b11, 16'hFFFF};
    dir_oob = 1'b0;
    max_idle = 0;
    rst_n = 1'b0;
    i_stall = 1'b0;
    i_branch_valid = 1'b0;
    i_branch_target = '0;

    // Straight-line program ending in the halt word.
    fill_mem(0);
    for (int i = 0; i < 5; i++) mem[i] = prog[i];
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      cycle(0, 0, 0);
      check("seq_valid", o_inst_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        check("seq_inst", o_inst, prog[c-2]);
        check("seq_pc", o_inst_pc, c - 2);
      end
      check("seq_halted", o_halted, c >= 6);
    end

    // Branch out of HALT back to 0.
    cycle(0, 1, 0);
    check("unhalt", o_halted, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("restart_valid", o_inst_valid, 1);
    check("restart_inst", o_inst, 16'hb300);
    check("restart_pc", o_inst_pc, 0);
`ifdef IFETCH_PERF_EN
    check("perf_fetched", o_perf_fetched, pops);
`endif

    // Stall five cycles with 0xb200 at the head.
    do_reset();
    repeat (3) cycle(0, 0, 0);
    check("stall_head_inst", o_inst, 16'hb200);
    check("stall_head_pc", o_inst_pc, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0);
      check("stall_inst", o_inst, 16'hb200);
      check("stall_pc", o_inst_pc, 1);
      check("stall_dir", o_dir, 3);
    end
    repeat (8) cycle(0, 0, 0);
    check("stall_all_delivered", exp_pc, 4);
    check("stall_halted", o_halted, 1);

    // Redirect to 6 while pc 2 is being fetched.
    do_reset();
    repeat (2) cycle(0, 0, 0);
    cycle(0, 1, 6);
    check("br_flush_valid", o_inst_valid, 0);
    cycle(0, 0, 0);
    check("br_gap_valid", o_inst_valid, 0);
    cycle(0, 0, 0);
    check("br_valid", o_inst_valid, 1);
    check("br_pc", o_inst_pc, 6);
    check("br_inst", o_inst, mem[6]);
`ifdef IFETCH_PERF_EN
    check("perf_flushed_nz", o_perf_flushed != 0, 1);
`endif

    // Run off the top of memory.
    fill_mem(0);
    do_reset();
    n = 0;
    while (!(o_halted && !o_inst_valid) && n < 400) begin
      cycle(0, 0, 0);
      n++;
    end
    check("top_done", o_halted && !o_inst_valid, 1);
    check("top_last_pc", exp_pc, MEM_DEPTH);
    check("top_max_dir", max_dir, MEM_DEPTH - 1);

    // Asynchronous reset with the skid buffer full.
    do_reset();
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    check("full_valid", o_inst_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", o_inst_valid, 0);
    check("async_dir", o_dir, 0);
    check("async_halted", o_halted, 0);
    do_reset();
    repeat (2) cycle(0, 0, 0);
    check("rerun_valid", o_inst_valid, 1);
    check("rerun_pc", o_inst_pc, 0);
    check("rerun_inst", o_inst, mem[0]);

    // Random stalls, branches and scattered halt words.
    fill_mem(8);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(9) < 3);
      br = o_halted ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0);
      cycle(stall, br, int'($urandom_range(279)));
    end
    check("rand_liveness", max_idle < 4, 1);
    check("rand_dir_bound", dir_oob, 0);
`ifdef IFETCH_PERF_EN
    check("rand_perf_fetched", o_perf_fetched, pops);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
